// File: rtl/ltc2387_receiver.sv
// ltc2387_receiver
// Drives an LTC2387-style ADC in two-lane DDR mode. Every SAMPLE_PERIOD
// cycles (while enabled) it issues a one-cycle cnv, waits CONV_CYCLES, then
// bursts 5 clk_out pulses. The ADC echoes each clk_out edge on dco together
// with one bit per lane. The echoed edges are captured in the clk domain
// after 2-flop synchronization.
//
// Ports
//   clk          single clock, rising edge
//   reset_n      synchronous active-low reset
//   enable       permits new conversion slots
//   cnv          conversion start (1-cycle pulse)
//   clk_out      gated readout clock to the ADC
//   dco          echoed data clock from the ADC (asynchronous)
//   da / db      lane 1 (odd bits D17..D1) / lane 2 (even bits D16..D0)
//   data         last fully captured sample, held between strobes
//   data_valid   1-cycle strobe when data updates
//   timeout_err  1-cycle strobe when a capture did not complete
module ltc2387_receiver #(
  parameter int ADC_WIDTH     = 18,  // only 18 is supported
  parameter int CONV_CYCLES   = 6,
  parameter int HALF_PERIOD   = 1,
  parameter int SAMPLE_PERIOD = 64,
  parameter int TIMEOUT       = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  output logic                 cnv,
  output logic                 clk_out,
  input  logic                 dco,
  input  logic                 da,
  input  logic                 db,
  output logic [ADC_WIDTH-1:0] data,
  output logic                 data_valid,
  output logic                 timeout_err
);

  localparam int NUM_EDGES = ADC_WIDTH / 2;  // two bits per dco edge
  localparam int TOGGLES   = 10;             // 5 clk_out pulses
  localparam int PW        = $clog2(SAMPLE_PERIOD + 1);
  localparam int TMAX      = (CONV_CYCLES > TIMEOUT) ? CONV_CYCLES : TIMEOUT;
  localparam int TW        = $clog2(TMAX + 1);
  localparam int HW        = $clog2(HALF_PERIOD + 1);
  localparam int EW        = $clog2(NUM_EDGES + 1);
  localparam int GW        = $clog2(TOGGLES + 1);

  typedef enum logic [2:0] {IDLE, CONV, CLOCK, DRAIN, DONE} state_e;

  // Synchronizers, bit order {dco, da, db}. Lanes go through the same depth
  // as dco, so data seen with a dco edge is the data the ADC launched with it.
  logic [2:0] s1_q, s2_q;
  logic       dco_prev_q;
  logic       dco_edge;

  state_e                 state_q, state_d;
  logic [PW-1:0]          per_q, per_d;
  logic [TW-1:0]          tmr_q, tmr_d;
  logic [HW-1:0]          hp_q, hp_d;
  logic [GW-1:0]          tog_q, tog_d;
  logic [EW-1:0]          ecnt_q, ecnt_d;
  logic [ADC_WIDTH-1:0]   sr_q, sr_d;
  logic [ADC_WIDTH-1:0]   data_q, data_d;
  logic                   cnv_q, cnv_d;
  logic                   clk_out_q, clk_out_d;
  logic                   dv_q, dv_d;
  logic                   to_q, to_d;
  logic                   capture;

  // Both dco polarities are data edges (DDR).
  assign dco_edge = s2_q[2] ^ dco_prev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      dco_prev_q <= 1'b0;
    end else begin
      s1_q       <= {dco, da, db};
      s2_q       <= s1_q;
      dco_prev_q <= s2_q[2];
    end
  end

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    tmr_d     = tmr_q;
    hp_d      = hp_q;
    tog_d     = tog_q;
    ecnt_d    = ecnt_q;
    sr_d      = sr_q;
    data_d    = data_q;
    cnv_d     = 1'b0;
    clk_out_d = clk_out_q;
    dv_d      = 1'b0;
    to_d      = 1'b0;
    capture   = 1'b0;

    // Slot counter runs only while enabled, so re-enabling always starts a
    // slot immediately.
    if (!enable)
      per_d = '0;
    else if (per_q == PW'(SAMPLE_PERIOD - 1))
      per_d = '0;
    else
      per_d = per_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (per_q == '0 && enable) begin
          cnv_d     = 1'b1;
          ecnt_d    = '0;
          sr_d      = '0;
          tmr_d     = '0;
          clk_out_d = 1'b0;
          state_d   = CONV;
        end
      end
      CONV: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TW'(CONV_CYCLES - 1)) begin
          // First toggle happens on entry so the rising edge lands exactly
          // CONV_CYCLES after cnv.
          clk_out_d = 1'b1;
          hp_d      = '0;
          tog_d     = GW'(1);
          state_d   = CLOCK;
        end
      end
      CLOCK: begin
        if (hp_q == HW'(HALF_PERIOD - 1)) begin
          hp_d      = '0;
          clk_out_d = ~clk_out_q;
          tog_d     = tog_q + 1'b1;
          // The 10th toggle is a falling edge; the drain timeout counts
          // from this edge.
          if (tog_q == GW'(TOGGLES - 1)) begin
            tmr_d   = '0;
            state_d = DRAIN;
          end
        end else begin
          hp_d = hp_q + 1'b1;
        end
      end
      DRAIN: begin
        tmr_d = tmr_q + 1'b1;
        if (tmr_q == TW'(TIMEOUT - 1)) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        data_d  = sr_q;
        dv_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Edge capture overrides the state actions above. Shifting two bits per
    // edge puts edge k at bits 17-2k/16-2k once all 9 edges are in.
    if ((state_q == CONV || state_q == CLOCK || state_q == DRAIN) &&
        dco_edge && ecnt_q < EW'(NUM_EDGES)) begin
      capture = 1'b1;
      sr_d    = {sr_q[ADC_WIDTH-3:0], s2_q[1], s2_q[0]};
      ecnt_d  = ecnt_q + 1'b1;
      if (ecnt_q == EW'(NUM_EDGES - 1)) begin
        // Complete sample beats a coincident timeout.
        clk_out_d = 1'b0;
        to_d      = 1'b0;
        state_d   = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      per_q     <= '0;
      tmr_q     <= '0;
      hp_q      <= '0;
      tog_q     <= '0;
      ecnt_q    <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      cnv_q     <= 1'b0;
      clk_out_q <= 1'b0;
      dv_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_q     <= per_d;
      tmr_q     <= tmr_d;
      hp_q      <= hp_d;
      tog_q     <= tog_d;
      ecnt_q    <= ecnt_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      cnv_q     <= cnv_d;
      clk_out_q <= clk_out_d;
      dv_q      <= dv_d;
      to_q      <= to_d;
    end
  end

  assign cnv         = cnv_q;
  assign clk_out     = clk_out_q;
  assign data        = data_q;
  assign data_valid  = dv_q;
  assign timeout_err = to_q;

endmodule

// File: tb/tb_ltc2387_receiver.sv
module tb_ltc2387_receiver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        cnv, clk_out, data_valid, timeout_err;
  logic        dco = 1'b0, da = 1'b0, db = 1'b0;
  logic [17:0] data;

  ltc2387_receiver #(
    .ADC_WIDTH(18), .CONV_CYCLES(6), .HALF_PERIOD(1),
    .SAMPLE_PERIOD(64), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cnv(cnv),
    .clk_out(clk_out), .dco(dco), .da(da), .db(db), .data(data),
    .data_valid(data_valid), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ADC model: each clk_out edge is echoed on dco with the next bit pair.
  logic [17:0] word_q[$];   // words the model returns, one per cnv
  logic [17:0] exp_q[$];    // scoreboard: expected data per data_valid
  int          n_edges = 9; // dco edges the model produces per conversion
  bit          model_en = 1'b1;
  int          conv_id = 0;
  logic [17:0] cur_word = '0;

  always @(posedge cnv) begin
    cur_word = (word_q.size() > 0) ? word_q.pop_front() : 18'h0;
    conv_id  = conv_id + 1;
  end

  int seen_id = 0;
  int k_edge  = 0;
  always @(posedge clk_out or negedge clk_out) begin
    #1;
    if (seen_id != conv_id) begin
      seen_id = conv_id;
      k_edge  = 0;
    end
    if (model_en && k_edge < n_edges) begin
      if (k_edge < 9) begin
        da = cur_word[17-2*k_edge];
        db = cur_word[16-2*k_edge];
      end else begin
        da = ~da;
        db = $urandom_range(0, 1);
      end
      dco = ~dco;
    end
    k_edge = k_edge + 1;
  end

  // Output monitor
  logic [17:0] obs_q[$];
  int          cnv_cyc[$];
  int          dv_cnt = 0, to_cnt = 0, cnv_cnt = 0;
  int          to_cyc = 0, last_edge_cyc = 0;
  logic        prev_clk_out = 1'b0;
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      obs_q.push_back(data);
      dv_cnt = dv_cnt + 1;
    end
    if (timeout_err === 1'b1) begin
      to_cnt = to_cnt + 1;
      to_cyc = cyc;
    end
    if (cnv === 1'b1) begin
      cnv_cnt = cnv_cnt + 1;
      cnv_cyc.push_back(cyc);
    end
    if (clk_out !== prev_clk_out) last_edge_cyc = cyc;
    prev_clk_out = clk_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic sb_drain();
    logic [17:0] o, e;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", {14'h0, o}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", {14'h0, o}, {14'h0, e});
      end
    end
  endtask

  int dv0, to0, g;

  initial begin
    // Reset state
    repeat (3) tick();
    chk("rst_cnv", cnv, 1'b0);
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_data", data, 18'h0);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);

    // Periodic conversions, then enable drops right after the third cnv
    word_q.push_back(18'h2AAAA); exp_q.push_back(18'h2AAAA);
    word_q.push_back(18'h15555); exp_q.push_back(18'h15555);
    word_q.push_back(18'h3FFFF); exp_q.push_back(18'h3FFFF);
    reset_n = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cnv_cnt >= 3) break;
    end
    enable = 1'b0;
    chk("wait_third_cnv", cnv_cnt, 3);
    repeat (3 * 64 + 10) tick();
    chk("periodic_cnv_count", cnv_cnt, 3);
    chk("periodic_dv_count", dv_cnt, 3);
    chk("periodic_no_timeout", to_cnt, 0);
    g = (cnv_cyc.size() >= 3) ? cnv_cyc[1] - cnv_cyc[0] : -1;
    chk("cnv_gap_1", g, 64);
    g = (cnv_cyc.size() >= 3) ? cnv_cyc[2] - cnv_cyc[1] : -1;
    chk("cnv_gap_2", g, 64);
    chk("data_after_periodic", data, 18'h3FFFF);
    sb_drain();

    // Only 6 dco edges: timeout, data held, no strobe
    dv0 = dv_cnt; to0 = to_cnt;
    n_edges = 6;
    word_q.push_back(18'h12345);
    enable = 1'b1; tick(); enable = 1'b0;
    repeat (60) tick();
    chk("short_timeout_count", to_cnt, to0 + 1);
    chk("short_no_valid", dv_cnt, dv0);
    chk("short_data_held", data, 18'h3FFFF);
    chk("short_timeout_delay", to_cyc - last_edge_cyc, 16);

    // 10 dco edges, the 10th carrying garbage
    dv0 = dv_cnt; to0 = to_cnt;
    n_edges = 10;
    word_q.push_back(18'h0C3A5); exp_q.push_back(18'h0C3A5);
    enable = 1'b1; tick(); enable = 1'b0;
    repeat (60) tick();
    chk("extra_edge_dv_count", dv_cnt, dv0 + 1);
    chk("extra_edge_no_timeout", to_cnt, to0);
    sb_drain();

    // Reset pulse during the clk_out burst
    dv0 = dv_cnt; to0 = to_cnt;
    n_edges = 9;
    word_q.push_back(18'h3C3C3);
    enable = 1'b1; tick(); enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (clk_out === 1'b1) break;
    end
    chk("reached_clock_burst", clk_out, 1'b1);
    reset_n = 1'b0; model_en = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midrst_clk_out", clk_out, 1'b0);
    chk("midrst_data", data, 18'h0);
    repeat (60) tick();
    chk("midrst_no_valid", dv_cnt, dv0);
    chk("midrst_no_timeout", to_cnt, to0);
    chk("midrst_data_held", data, 18'h0);

    // First cnv comes on the first enabled cycle after reset
    dv0 = dv_cnt;
    model_en = 1'b1;
    word_q.push_back(18'h00001); exp_q.push_back(18'h00001);
    enable = 1'b1; tick();
    chk("first_cnv_after_reset", cnv, 1'b1);
    enable = 1'b0;
    repeat (40) tick();
    chk("post_reset_dv_count", dv_cnt, dv0 + 1);
    sb_drain();
    chk("sb_all_consumed", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
